poly_operand_loader: RTL and testbench

- Front-end stage directly upstream of the polynomial evaluator.
- Turns the raw go push-button and 8-bit switch word into four cleanly captured operands (A, B, C, X) and presents them as one bundle over a valid/ready handshake.
- Replaces per-press load strobes with synchronised, debounced, one-capture-per-press loading.
- The evaluator consumes the bundle when it is idle.

---
 rtl/poly_pkg.sv | 16 +
 rtl/poly_operand_loader_go_debouncer.sv | 45 ++++
 rtl/poly_operand_loader.sv | 80 ++++++++
 tb/tb_poly_operand_loader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared constants and the loader state encoding for the polynomial operand front end.
package poly_pkg;

  localparam int DATA_W_DEFAULT = 8;

  localparam logic [1:0] OP_SLOT_A = 2'd0;
  localparam logic [1:0] OP_SLOT_B = 2'd1;
  localparam logic [1:0] OP_SLOT_C = 2'd2;
  localparam logic [1:0] OP_SLOT_X = 2'd3;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } load_state_t;

endpackage

// File: rtl/poly_operand_loader_go_debouncer.sv
// Two-flop synchroniser plus stability counter; level_out follows in_raw after DEBOUNCE_CYCLES+2 edges.
// rise_pulse is combinational and marks the edge on which level_out will go 0->1; no backpressure.
module go_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  output logic level_out,
  output logic rise_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             go_sync;
  logic [CNT_W-1:0] cnt;
  logic             settle;

  // settle is true on exactly the edge where the new level is accepted
  assign settle     = (go_sync != level_out) && (cnt == CNT_MAX);
  assign rise_pulse = settle && go_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1   <= 1'b0;
      go_sync   <= 1'b0;
      level_out <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_q1 <= in_raw;
      go_sync <= sync_q1;
      if (go_sync == level_out) begin
        cnt <= '0;
      end else if (settle) begin
        level_out <= go_sync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/poly_operand_loader.sv
// Collects A/B/C/X from debounced button presses and offers them as one bundle over valid/ready.
// Capture lands on the debounce-accept edge; while the bundle waits for op_ready, presses are dropped.
module poly_operand_loader
  import poly_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go_raw,
  input  logic [DATA_W-1:0] data_in,
  input  logic              op_ready,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] op_c,
  output logic [DATA_W-1:0] op_x,
  output logic [1:0]        op_index,
  output logic              pressed
);

  load_state_t state;
  logic        go_db;
  logic        press_evt;

  go_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_go_debouncer (
    .clk       (clk),
    .reset     (reset),
    .in_raw    (go_raw),
    .level_out (go_db),
    .rise_pulse(press_evt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      op_valid <= 1'b0;
      op_index <= OP_SLOT_A;
      pressed  <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_c     <= '0;
      op_x     <= '0;
    end else begin
      pressed <= 1'b0;
      case (state)
        COLLECT: begin
          if (press_evt) begin
            pressed <= 1'b1;
            case (op_index)
              OP_SLOT_A: op_a <= data_in;
              OP_SLOT_B: op_b <= data_in;
              OP_SLOT_C: op_c <= data_in;
              default:   op_x <= data_in;
            endcase
            if (op_index == OP_SLOT_X) begin
              op_valid <= 1'b1;
              state    <= PRESENT;
            end else begin
              op_index <= op_index + 2'd1;
            end
          end
        end
        PRESENT: begin
          // a press landing on the handshake edge is intentionally lost
          if (op_valid && op_ready) begin
            op_valid <= 1'b0;
            op_index <= OP_SLOT_A;
            state    <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_operand_loader.sv
// Directed bench for poly_operand_loader with DEBOUNCE_CYCLES=4.
module tb_poly_operand_loader;

  localparam int DW  = 8;
  localparam int DEB = 4;
  // go_raw set before edge k counts that edge as 1; capture lands on edge k+1+DEB
  localparam int LAT = DEB + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go_raw = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          op_ready = 1'b0;
  logic          op_valid;
  logic [DW-1:0] op_a, op_b, op_c, op_x;
  logic [1:0]    op_index;
  logic          pressed;

  int tests = 0;
  int fails = 0;
  int hit;
  int npress;

  poly_operand_loader #(
    .DATA_W         (DW),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .go_raw  (go_raw),
    .data_in (data_in),
    .op_ready(op_ready),
    .op_valid(op_valid),
    .op_a    (op_a),
    .op_b    (op_b),
    .op_c    (op_c),
    .op_x    (op_x),
    .op_index(op_index),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the button for 8 edges, report the edge (1-based) of the first pressed pulse or -1, then release.
  task automatic press(input logic [DW-1:0] d, output int hit_edge);
    data_in  = d;
    go_raw   = 1'b1;
    hit_edge = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (pressed && hit_edge < 0) hit_edge = i;
    end
    go_raw = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_valid", {31'd0, op_valid}, 32'd0);
    check("rst_index", {30'd0, op_index}, 32'd0);
    check("rst_pressed", {31'd0, pressed}, 32'd0);
    check("rst_ops", {op_a, op_b, op_c, op_x}, 32'd0);

    // four clean presses, op_ready low
    press(8'h05, hit);
    check("p1_latency", hit, LAT);
    check("p1_index", {30'd0, op_index}, 32'd1);
    press(8'h03, hit);
    check("p2_latency", hit, LAT);
    check("p2_index", {30'd0, op_index}, 32'd2);
    press(8'h02, hit);
    check("p3_latency", hit, LAT);
    check("p3_index", {30'd0, op_index}, 32'd3);
    check("p3_valid", {31'd0, op_valid}, 32'd0);
    press(8'h04, hit);
    check("p4_latency", hit, LAT);
    check("p4_index", {30'd0, op_index}, 32'd3);
    check("p4_valid", {31'd0, op_valid}, 32'd1);
    check("bundle", {op_a, op_b, op_c, op_x}, 32'h05030204);

    // presses ignored while the bundle waits
    for (int n = 0; n < 3; n++) begin
      press(8'hEE, hit);
      check("present_ignore", hit, -1);
    end
    check("present_frozen", {op_a, op_b, op_c, op_x}, 32'h05030204);
    check("present_valid", {31'd0, op_valid}, 32'd1);

    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("hs_valid", {31'd0, op_valid}, 32'd0);
    check("hs_index", {30'd0, op_index}, 32'd0);
    press(8'h11, hit);
    check("after_hs_latency", hit, LAT);
    check("after_hs_ops", {op_a, op_b, op_c, op_x}, 32'h11030204);

    // a 3-cycle pulse is too short to be accepted
    npress = 0;
    go_raw = 1'b1;
    repeat (3) tick();
    go_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pressed) npress++;
    end
    check("short_pulse", npress, 0);
    check("short_index", {30'd0, op_index}, 32'd1);

    // bouncing 1,0,1,0 then held: one capture LAT edges after the final rise
    data_in = 8'h7A;
    npress  = 0;
    for (int i = 0; i < 4; i++) begin
      go_raw = (i % 2 == 0);
      tick();
      if (pressed) npress++;
    end
    press(8'h7A, hit);
    check("bounce_early", npress, 0);
    check("bounce_latency", hit, LAT);
    check("bounce_opb", {24'd0, op_b}, 32'h7A);
    check("bounce_index", {30'd0, op_index}, 32'd2);

    // reset mid-debounce with the button held
    data_in = 8'h3C;
    go_raw  = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ops", {op_a, op_b, op_c, op_x}, 32'd0);
    check("mid_rst_ctl", {29'd0, op_valid, op_index}, 32'd0);
    check("mid_rst_pressed", {31'd0, pressed}, 32'd0);
    hit = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (pressed && hit < 0) hit = i;
    end
    go_raw = 1'b0;
    repeat (8) tick();
    check("held_latency", hit, LAT);
    check("held_opa", {24'd0, op_a}, 32'h3C);
    check("held_index", {30'd0, op_index}, 32'd1);

    // refill B/C/X, then land a press on the handshake edge
    press(8'h21, hit);
    press(8'h22, hit);
    press(8'h23, hit);
    check("refill_valid", {31'd0, op_valid}, 32'd1);
    data_in = 8'h99;
    go_raw  = 1'b1;
    repeat (LAT - 1) tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("coll_valid", {31'd0, op_valid}, 32'd0);
    check("coll_index", {30'd0, op_index}, 32'd0);
    check("coll_pressed", {31'd0, pressed}, 32'd0);
    check("coll_ops", {op_a, op_b, op_c, op_x}, 32'h3C212223);
    go_raw = 1'b0;
    repeat (8) tick();
    check("coll_no_late", {30'd0, op_index}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
